hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core. It watches the ID-stage instruction, the EX-stage destination and the memory-ready status, and drives the stall, flush and bubble enables for the PC, IF/ID, ID/EX and EX/MEM registers. It sequences redirect flushes over the fetch latency and freezes the pipe on multi-cycle data-memory accesses. It sits beside the decode stage and is the single owner of all pipeline-register enables.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_reg_use_decode.sv | 43 ++++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Purpose : shared opcode constants and FSM state encoding for the hazard controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_reg_use_decode.sv
// Purpose : decode which source registers the ID-stage instruction reads.
// Latency : purely combinational, same cycle.
// Backpressure: none; no state.
// Ports   : i_instr (ID instruction) -> o_uses_rs1/o_uses_rs2 flags, o_rs1/o_rs2 indices.
module reg_use_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);

  // Fields that never influence register usage.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_instr[31:25], i_instr[14:7]};

  assign o_rs1 = i_instr[19:15];
  assign o_rs2 = i_instr[24:20];

  always_comb begin
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    case (i_instr[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin
        o_uses_rs1 = 1'b1;
        o_uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        o_uses_rs1 = 1'b1;
      end
      // LUI/AUIPC/JAL and unknown opcodes read no registers
      OP_LUI, OP_AUIPC, OP_JAL: begin
        o_uses_rs1 = 1'b0;
      end
      default: begin
        o_uses_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : stall/flush/bubble controller owning every pipeline-register enable of the 5-stage core.
// Latency : enables are combinational from state + inputs in the same cycle; state updates on clk.
// Backpressure: mem_busy freezes the whole pipe and overrides redirect and load-use handling.
// Ports   : ID instr/valid, EX rd/load/valid/redirect, mem_busy in; pc_stall, ifid_stall,
//           ifid_flush, idex_bubble, pipe_freeze out; stall_cnt/flush_cnt only with HAZARD_PERF_EN.
// Config  : define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_valid,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [3:0] FCNT_RELOAD = 4'(FETCH_LAT - 1);

  state_t     r_state;
  state_t     r_ret_state;
  logic [3:0] r_fcnt;

  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_load_use;
  state_t     w_cur;

  reg_use_decode u_decode (
    .i_instr    (id_instr),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2)
  );

  assign w_load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                      ((w_uses_rs1 & (w_rs1 == ex_rd)) | (w_uses_rs2 & (w_rs2 == ex_rd)));

  // Once memory is ready again, the cycle is handled as if we were in the saved state.
  assign w_cur = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (mem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (w_cur == ST_FLUSH || ex_redirect) begin
      // load-use is irrelevant here: the ID instruction is wrong-path and gets flushed
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_fcnt      <= 4'd0;
    end else if (mem_busy) begin
      // EX keeps the redirect until memory frees up, so it is not lost here.
      r_state <= ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) begin
        r_ret_state <= r_state;
      end
    end else begin
      r_state <= w_cur;
      if (w_cur == ST_FLUSH) begin
        if (ex_redirect) begin
          r_fcnt <= FCNT_RELOAD;
        end else if (r_fcnt == 4'd1) begin
          r_state <= ST_RUN;
          r_fcnt  <= 4'd0;
        end else begin
          r_fcnt <= r_fcnt - 4'd1;
        end
      end else if (ex_redirect && FETCH_LAT > 1) begin
        r_state <= ST_FLUSH;
        r_fcnt  <= FCNT_RELOAD;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (ifid_flush && r_flush_cnt != '1) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : self-checking bench for hazard_ctrl with directed scenarios and random traffic.
// Latency : outputs compared mid-cycle against a cycle-level behavioural model.
// Backpressure: mem_busy exercised both directed and randomly.
module tb_hazard_ctrl;

  localparam int FL = 3;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_valid;
  logic        ex_redirect;
  logic        mem_busy;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.FETCH_LAT(FL), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_valid    (ex_valid),
    .ex_redirect (ex_redirect),
    .mem_busy    (mem_busy),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pipe_freeze (pipe_freeze)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: wrong-path fetch cycles still owed after this one, and event tallies.
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [4:0] exp_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic u1, u2;
    u1 = 1'b0;
    u2 = 1'b0;
    case (ins[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin u1 = 1'b1; u2 = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: u1 = 1'b1;
      default: u1 = 1'b0;
    endcase
    return (u1 && ins[19:15] == r) || (u2 && ins[24:20] == r);
  endfunction

  // Expected {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}
  function automatic logic [4:0] model_out();
    logic lu;
    lu = ex_valid && ex_mem_read && ex_rd != 5'd0 && id_valid && reads_reg(id_instr, ex_rd);
    if (rst)                          return 5'b00000;
    else if (mem_busy)                return 5'b11001;
    else if (m_left > 0 || ex_redirect) return 5'b00110;
    else if (lu)                      return 5'b11010;
    else                              return 5'b00000;
  endfunction

  task automatic step(input string tag);
    #1;
    exp_o = model_out();
    check(tag, {27'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}, {27'd0, exp_o});
`ifdef HAZARD_PERF_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), rst ? 32'd0 : 32'(m_stall));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), rst ? 32'd0 : 32'(m_flush));
`endif
    @(posedge clk);
    if (rst) begin
      m_left  = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (exp_o[4] && m_stall < (2**CW) - 1) m_stall++;
      if (exp_o[2] && m_flush < (2**CW) - 1) m_flush++;
      if (!mem_busy) begin
        if (ex_redirect)     m_left = FL - 1;
        else if (m_left > 0) m_left--;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_instr    = 32'h0000_0013;
    id_valid    = 1'b0;
    ex_rd       = 5'd0;
    ex_mem_read = 1'b0;
    ex_valid    = 1'b0;
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
  endtask

  logic [6:0] ops [10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
                           7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};

  initial begin
    rst = 1'b1;
    idle();
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle");

    // lw x5 in EX, add x6,x5,x1 in ID -> single stall, then bubble reaches EX
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_valid = 1'b1;
    id_instr = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
    step("load_use");
    check("load_use_const", {27'd0, exp_o}, 32'h1A);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    step("load_use_after");

    // lw x0 with ID reading x0: no hazard
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
    id_instr = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
    step("x0_no_stall");
    // lui x5 reads nothing
    ex_rd = 5'd5;
    id_instr = {20'h05050, 5'd5, 7'b0110111};
    step("lui_no_stall");
    idle();

    // one-cycle redirect -> FL flush cycles
    ex_redirect = 1'b1;
    step("redir0");
    ex_redirect = 1'b0;
    for (int i = 1; i < FL; i++) step("redir_flush");
    step("redir_done");

    // redirect, then mem_busy 4 cycles while the flush is pending
    ex_redirect = 1'b1;
    step("redir_mb0");
    ex_redirect = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("freeze");
    mem_busy = 1'b0;
    step("flush_resume0");
    step("flush_resume1");
    step("flush_resume_done");

    // redirect and load-use together -> flush only
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_valid = 1'b1;
    id_instr = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
    ex_redirect = 1'b1;
    step("redir_and_lu");
    check("redir_and_lu_const", {27'd0, exp_o}, 32'h06);
    idle();
    step("redir_and_lu_1");

    // reset mid-flush
    idle();
    ex_redirect = 1'b1;
    step("pre_rst_redir");
    ex_redirect = 1'b0;
    rst = 1'b1;
    step("rst_mid_flush");
    rst = 1'b0;
    step("after_rst");
    step("after_rst2");

    // random traffic with small register numbers to provoke matches
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      id_instr    = ins;
      id_valid    = ($urandom_range(0, 3) != 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_mem_read = $urandom_range(0, 1) == 1;
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_redirect = ($urandom_range(0, 5) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      rst         = ($urandom_range(0, 60) == 0);
      step("random");
    end
    rst = 1'b0;
    idle();
    step("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
